// File: rtl/seq_sub64.sv
// ---------------------------------------------------------------------------
// seq_sub64
//   Multi-cycle two's-complement subtractor: diff = a - b - borrow_in over
//   WIDTH bits. It computes CHUNK bits per clock, reusing a single
//   (CHUNK+1)-bit adder slice. The carry between slices is kept in a register,
//   so the ripple carry travels across clock cycles.
//
//   The subtraction is done as a + ~b + ~borrow_in. The inverted borrow acts
//   as the carry into the lowest chunk. The carry out of the top chunk is the
//   inverted borrow_out.
//
//   Ports
//     clk        : single clock, all state updates on the rising edge
//     rst_n      : synchronous active-low reset
//     in_valid   : a, b, borrow_in are presented
//     in_ready   : block can accept an operation (high only in IDLE)
//     a, b       : minuend / subtrahend (WIDTH bits)
//     borrow_in  : incoming borrow
//     out_valid  : result outputs are valid (held until out_ready)
//     out_ready  : consumer accepts the result
//     diff       : a - b - borrow_in mod 2^WIDTH
//     borrow_out : unsigned a < b + borrow_in
//     overflow   : signed overflow of the subtraction
//     zero       : diff == 0
//
//   WIDTH must be an exact multiple of CHUNK.
// ---------------------------------------------------------------------------
module seq_sub64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic             carry;
  // The operand registers shift right by one chunk per RUN cycle, so the
  // adder always reads the low chunk. On the last chunk, the low chunk holds
  // the operand MSBs that the overflow rule needs.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] nb_sh;
  // Set while every chunk written so far in this operation has been zero.
  logic             all_zero;

  logic [CHUNK:0]   slice_sum;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic             chunk_zero;
  logic             last_chunk;
  logic             a_msb;
  logic             b_msb;

  // The single adder slice shared by every chunk.
  assign slice_sum  = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, nb_sh[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry};
  assign slice_s    = slice_sum[CHUNK-1:0];
  assign slice_c    = slice_sum[CHUNK];
  assign chunk_zero = (slice_s == '0);
  assign last_chunk = (idx == LAST_IDX);

  // Only meaningful on the last chunk, when the top bits sit in the low chunk.
  // b_msb is recovered by inverting the stored ~b.
  assign a_msb = a_sh[CHUNK-1];
  assign b_msb = ~nb_sh[CHUNK-1];

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      a_sh       <= '0;
      nb_sh      <= '0;
      all_zero   <= 1'b0;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            nb_sh    <= ~b;
            carry    <= ~borrow_in;
            idx      <= '0;
            all_zero <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          // Place this chunk of the result at its final bit position. Bits
          // above the current chunk still hold stale data until written.
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
              diff[i*CHUNK +: CHUNK] <= slice_s;
            end
          end
          carry    <= slice_c;
          a_sh     <= a_sh >> CHUNK;
          nb_sh    <= nb_sh >> CHUNK;
          all_zero <= all_zero & chunk_zero;
          idx      <= idx + 1'b1;

          if (last_chunk) begin
            // A carry out of a + ~b + ~bin means no borrow was needed.
            borrow_out <= ~slice_c;
            overflow   <= (a_msb != b_msb) && (slice_s[CHUNK-1] != a_msb);
            zero       <= all_zero & chunk_zero;
            out_valid  <= 1'b1;
            idx        <= '0;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub64.sv
module tb_seq_sub64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_sub64 #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  // Reference model: plain wide arithmetic straight from the definitions.
  function automatic res_t model(logic [63:0] ma, logic [63:0] mb, logic mbin);
    res_t r;
    r.d  = ma - mb - 64'(mbin);
    r.bo = ({1'b0, ma} < ({1'b0, mb} + 65'(mbin)));
    r.ov = (ma[63] != mb[63]) && (r.d[63] != ma[63]);
    r.z  = (r.d == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process (every cycle, at negedge) -------------
  res_t exp_q[$];
  int   accept_edge = -1;
  bit   prev_ov_valid = 1'b0;
  bit   expect_idle = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_ov_valid = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("mon_in_ready_after_pop", 64'(in_ready), 64'd1);
        chk("mon_out_valid_after_pop", 64'(out_valid), 64'd0);
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        chk("mon_in_ready_low_hold", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_ov_valid)
            chk("mon_latency", 64'(cyc - accept_edge), 64'd4);
          chk("mon_diff", diff, exp_q[0].d);
          chk("mon_borrow", 64'(borrow_out), 64'(exp_q[0].bo));
          chk("mon_overflow", 64'(overflow), 64'(exp_q[0].ov));
          chk("mon_zero", 64'(zero), 64'(exp_q[0].z));
          if (out_ready) begin
            void'(exp_q.pop_front());
            expect_idle = 1'b1;
          end
        end
      end
      prev_ov_valid = out_valid && !out_ready;
      // Inputs are stable here; an accept happens on the coming edge.
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, borrow_in));
        accept_edge = cyc + 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [63:0] oa, input logic [63:0] ob, input logic obin);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("start_timeout", 64'(in_ready), 64'd1);
    a = oa; b = ob; borrow_in = obin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) chk("wait_out_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic do_op(input string nm, input logic [63:0] oa, input logic [63:0] ob,
                       input logic obin, input logic [63:0] ed, input logic eb,
                       input logic eo, input logic ez);
    int lat;
    out_ready = 1'b1;
    start_op(oa, ob, obin);
    wait_out(lat);
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_borrow"}, 64'(borrow_out), 64'(eb));
    chk({nm, "_overflow"}, 64'(overflow), 64'(eo));
    chk({nm, "_zero"}, 64'(zero), 64'(ez));
    tick();
    chk({nm, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({nm, "_in_ready_back"}, 64'(in_ready), 64'd1);
    $display("op %s: a=%h b=%h bin=%0d diff=%h bo=%0d ov=%0d z=%0d",
             nm, oa, ob, obin, diff, borrow_out, overflow, zero);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_diff", diff, 64'd0);
    chk("reset_flags", {61'd0, borrow_out, overflow, zero}, 64'd0);

    do_op("t1_5m3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    do_op("t2_0m1", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("t2_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
          64'd0, 1'b0, 1'b0, 1'b1);
    do_op("t3_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_op("t4_chain", 64'h0000_0001_0000_0000, 64'd1, 1'b1,
          64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("neg_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    do_op("bin_zero", 64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, new operands ignored.
    out_ready = 1'b0;
    start_op(64'd100, 64'd58, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 64'hDEAD_BEEF_0000_0000 + 64'(i); b = 64'd7; borrow_in = 1'b1;
      tick();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_diff", diff, 64'd42);
      chk("bp_borrow", 64'(borrow_out), 64'd0);
      $display("backpressure cycle %0d: diff=%h out_valid=%0d in_ready=%0d", i, diff, out_valid, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_retain_diff", diff, 64'd42);

    // Reset in the middle of RUN discards the operation.
    start_op(64'hFFFF_0000_FFFF_0000, 64'h1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_diff", diff, 64'd0);
    chk("midrst_borrow", 64'(borrow_out), 64'd0);
    $display("mid-run reset: in_ready=%0d out_valid=%0d diff=%h", in_ready, out_valid, diff);
    do_op("after_rst_7m2", 64'd7, 64'd2, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0);

    tick(); tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_sub64.md
Name: seq_sub64

Overview:
- Multi-cycle two's-complement subtractor: computes diff = a - b - borrow_in over WIDTH bits, CHUNK bits per clock.
- Companion to the 64-bit ripple-carry adder datapath: the subtract direction, with registered operands and valid/ready handshakes on both sides.
- Internally one CHUNK-bit adder slice is reused each cycle, with a carry register between slices (ripple across time).
- Sits between operand registers and the result consumer in the ALU path.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 16, bits processed per cycle. WIDTH must be an exact multiple of CHUNK. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a, b, borrow_in present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  incoming borrow.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - borrow_in, mod 2^WIDTH.
- borrow_out  output  1  1 when the unsigned value a < b + borrow_in.
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - diff, borrow_out, overflow, zero all 0.
  - Chunk index and carry register cleared.
  - Applies from any state; an in-flight operation is discarded with no result produced.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch a and ~b, set carry=~borrow_in, set idx=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle computes {c, s} = a_chunk[idx] + nb_chunk[idx] + carry.
  - Writes s into diff[idx*CHUNK +: CHUNK], sets carry=c, increments idx.
  - After chunk NCHUNK-1 is written: borrow_out=~c, overflow and zero are computed from the complete diff, out_valid=1, go to HOLD.
- Latency: out_valid is high starting NCHUNK cycles after the accepting edge (4 cycles at defaults).
- diff bits above the current chunk are undefined during RUN; consumers sample only when out_valid=1.
- HOLD:
  - out_valid=1.
  - diff, borrow_out, overflow and zero are stable while out_ready=0.
  - in_ready=0.
  - On out_valid&out_ready: out_valid=0, go to IDLE. in_ready=1 from the next cycle; there is no same-cycle turnaround.
- Throughput: one operation per NCHUNK+2 cycles minimum.
- diff, borrow_out, overflow and zero retain their last values in IDLE until the next operation overwrites them.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Only one CHUNK+1-bit adder is instantiated; no full-width adder.
  - zero and overflow are registered, not combinational outputs.

Test Plan:
1. a=5, b=3, borrow_in=0 -> diff=2, borrow_out=0, overflow=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
2. a=0, b=1, borrow_in=0 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow_out=1, overflow=0. Then a=b=64'h1234_5678_9ABC_DEF0 -> diff=0, zero=1, borrow_out=0.
3. a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, overflow=1, borrow_out=0.
4. Inter-chunk borrow propagation: a=64'h0000_0001_0000_0000, b=1, borrow_in=1 -> diff=64'h0000_0000_FFFF_FFFE, borrow_out=0.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid, and drive in_valid=1 with new operands -> outputs unchanged, in_ready=0, new operands ignored. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
6. Reset mid-operation: deassert rst_n for 1 edge, 2 cycles into RUN -> next cycle in_ready=1, out_valid=0, diff=0, borrow_out=0. A following op 7-2 yields diff=5 with normal latency.
